// File: rtl/cdc_data_rx_pkg.sv
// Shared definitions for the cdc_data_rx receive end of the req/ack word link.
// Holds the FSM state encoding and default synchronizer depth.
package cdc_data_rx_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;

   // Occupancy value at which the two-entry skid buffer is full.
   localparam logic [1:0] SKID_FULL = 2'd2;

endpackage

// File: rtl/cdc_data_rx_sync.sv
// cdc_sync_bit: plain flop-chain level synchronizer with synchronous active-low reset.
// Used for src_req here and reusable by the sender to bring src_ack back.
module cdc_sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // Shift the asynchronous level in from bit 0 toward the output bit.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
   end

   // Chain registers; cleared on reset so a held request is not seen until released.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_data_rx.sv
// cdc_data_rx: destination end of a 4-phase req/ack word crossing.
// Synchronizes src_req, captures the stable src_data word, returns a level ack and
// presents captured words on a registered valid/ready interface.
// Build option CDC_DATA_RX_SKID_EN: two-entry FIFO buffer instead of one holding register.
module cdc_data_rx
   import cdc_data_rx_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              src_req,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_ack,
   output logic [DATA_W-1:0] dst_data,
   output logic              dst_valid,
   input  logic              dst_ready,
   output logic              busy
);

   logic              req_s;
   state_t            state_q, state_d;
   logic              src_ack_q, src_ack_d;
   logic              dst_valid_q, dst_valid_d;
   logic [DATA_W-1:0] dst_data_q, dst_data_d;
   logic              pop;
   logic              space;
   logic              capture;

   cdc_sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_req_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .d_i    (src_req),
      .q_o    (req_s)
   );

   assign pop = dst_valid_q && dst_ready;

   // Handshake FSM: capture once per request high-phase, hold ack until request drops.
   always_comb begin
      state_d   = state_q;
      src_ack_d = src_ack_q;
      capture   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // src_data has been stable for at least SYNC_STAGES cycles once req_s is seen.
            if (req_s && space) begin
               capture   = 1'b1;
               src_ack_d = 1'b1;
               state_d   = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!req_s) begin
               src_ack_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            src_ack_d = 1'b0;
         end
      endcase
   end

   // FSM and ack registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         src_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_ack_q <= src_ack_d;
      end
   end

`ifdef CDC_DATA_RX_SKID_EN
   logic [DATA_W-1:0] mem_q [2];
   logic [DATA_W-1:0] mem_d [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        cnt_q, cnt_d;

   // A full FIFO can still accept when the head leaves on the same edge.
   assign space = (cnt_q != SKID_FULL) || pop;

   // FIFO next state; output register is loaded with the next head so it stays registered.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (capture) begin
         mem_d[wr_ptr_q] = src_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({capture, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
      dst_valid_d = (cnt_d != 2'd0);
      dst_data_d  = mem_d[rd_ptr_d];
   end

   // FIFO storage, pointers and registered head.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_q[0]    <= '0;
         mem_q[1]    <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
         dst_valid_q <= 1'b0;
         dst_data_q  <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         dst_valid_q <= dst_valid_d;
         dst_data_q  <= dst_data_d;
      end
   end
`else
   // Single holding register: free when empty or being consumed this edge.
   assign space = !dst_valid_q || pop;

   // Holding register next state; a capture overrides a same-edge pop.
   always_comb begin
      dst_valid_d = dst_valid_q;
      dst_data_d  = dst_data_q;
      if (capture) begin
         dst_valid_d = 1'b1;
         dst_data_d  = src_data;
      end else if (pop) begin
         dst_valid_d = 1'b0;
      end
   end

   // Holding register doubles as the output register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dst_valid_q <= 1'b0;
         dst_data_q  <= '0;
      end else begin
         dst_valid_q <= dst_valid_d;
         dst_data_q  <= dst_data_d;
      end
   end
`endif

   assign src_ack   = src_ack_q;
   assign dst_valid = dst_valid_q;
   assign dst_data  = dst_data_q;
   assign busy      = (state_q != ST_IDLE) || dst_valid_q;

endmodule

// File: tb/tb_cdc_data_rx.sv
// Directed bench for cdc_data_rx; adapts buffer-depth expectations to CDC_DATA_RX_SKID_EN.
module tb_cdc_data_rx;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       src_req;
   logic [7:0] src_data;
   logic       src_ack;
   logic [7:0] dst_data;
   logic       dst_valid;
   logic       dst_ready;
   logic       busy;

   int         n_tot = 0;
   int         n_bad = 0;
   logic [7:0] rxq [$];
   bit         words_done;

   cdc_data_rx #(
      .DATA_W     (8),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .src_req  (src_req),
      .src_data (src_data),
      .src_ack  (src_ack),
      .dst_data (dst_data),
      .dst_valid(dst_valid),
      .dst_ready(dst_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Record every accepted word; inputs settle after posedge so negedge shows the next edge's pop.
   always @(negedge clk) begin
      if (reset_n && dst_valid && dst_ready) rxq.push_back(dst_data);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] d);
      int n;
      src_data = d;
      src_req  = 1'b1;
      n = 0;
      while (!src_ack && n < 200) begin tick(); n++; end
      chk("ack_rise", {31'd0, src_ack}, 32'd1);
      src_req = 1'b0;
      n = 0;
      while (src_ack && n < 200) begin tick(); n++; end
      chk("ack_fall", {31'd0, src_ack}, 32'd0);
   endtask

   task automatic drain();
      dst_ready = 1'b1;
      repeat (6) tick();
      chk("drained", {31'd0, dst_valid}, 32'd0);
   endtask

   task automatic chk_rx(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input int n);
      logic [7:0] exp_w [3];
      exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2;
      chk({tag, "_cnt"}, rxq.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < rxq.size()) chk({tag, "_word"}, {24'd0, rxq[i]}, {24'd0, exp_w[i]});
      end
   endtask

   initial begin
      int n;
      reset_n   = 1'b0;
      src_req   = 1'b1;
      src_data  = 8'h00;
      dst_ready = 1'b0;

      // 1: reset held with request high
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_ack", {31'd0, src_ack}, 32'd0);
         chk("rst_valid", {31'd0, dst_valid}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
      end
      chk("rst_data", {24'd0, dst_data}, 32'd0);
      src_req = 1'b0;
      reset_n = 1'b1;
      repeat (3) tick();
      chk("idle_ack", {31'd0, src_ack}, 32'd0);

      // 2: single word, latency 3
      rxq.delete();
      dst_ready = 1'b1;
      src_data  = 8'hA5;
      src_req   = 1'b1;
      tick(); tick();
      chk("lat_early_valid", {31'd0, dst_valid}, 32'd0);
      chk("lat_early_ack", {31'd0, src_ack}, 32'd0);
      tick();
      chk("lat_valid", {31'd0, dst_valid}, 32'd1);
      chk("lat_data", {24'd0, dst_data}, 32'hA5);
      chk("lat_ack", {31'd0, src_ack}, 32'd1);
      chk("lat_busy", {31'd0, busy}, 32'd1);
      src_req = 1'b0;
      n = 0;
      while (src_ack && n < 20) begin tick(); n++; end
      chk("ack_fall_lat", {31'd0, (n >= 2 && n <= 3)}, 32'd1);
      tick();
      chk("single_busy", {31'd0, busy}, 32'd0);
      chk_rx("single", 8'hA5, 8'h00, 8'h00, 1);

      // 3: consumer stall
      rxq.delete();
      dst_ready = 1'b0;
      send_word(8'h11);
`ifdef CDC_DATA_RX_SKID_EN
      send_word(8'h22);
      chk("stall_head", {24'd0, dst_data}, 32'h11);
      src_data = 8'h33;
`else
      src_data = 8'h22;
`endif
      src_req = 1'b1;
      repeat (8) tick();
      chk("stall_ack", {31'd0, src_ack}, 32'd0);
      chk("stall_hold", {24'd0, dst_data}, 32'h11);
      chk("stall_valid", {31'd0, dst_valid}, 32'd1);
      dst_ready = 1'b1;
      n = 0;
      while (!src_ack && n < 20) begin tick(); n++; end
      chk("stall_release", {31'd0, src_ack}, 32'd1);
      src_req = 1'b0;
      n = 0;
      while (src_ack && n < 20) begin tick(); n++; end
      drain();
`ifdef CDC_DATA_RX_SKID_EN
      chk_rx("stall", 8'h11, 8'h22, 8'h33, 3);
`else
      chk_rx("stall", 8'h11, 8'h22, 8'h00, 2);
`endif

      // 4: back-to-back with random consumer
      rxq.delete();
      words_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++) send_word(i[7:0]);
            words_done = 1'b1;
         end
         begin
            while (!words_done) begin
               dst_ready = ($urandom_range(0, 1) == 1);
               tick();
            end
         end
      join
      drain();
      chk("b2b_cnt", rxq.size(), 16);
      n = 0;
      for (int i = 0; i < rxq.size(); i++) if (rxq[i] != i[7:0]) n++;
      chk("b2b_order", n, 0);

      // 5: reset while in ACK with a buffered word
      rxq.delete();
      dst_ready = 1'b0;
      src_data  = 8'h5A;
      src_req   = 1'b1;
      n = 0;
      while (!src_ack && n < 20) begin tick(); n++; end
      chk("mid_ack", {31'd0, src_ack}, 32'd1);
      reset_n = 1'b0;
      tick();
      chk("mid_rst_valid", {31'd0, dst_valid}, 32'd0);
      chk("mid_rst_ack", {31'd0, src_ack}, 32'd0);
      reset_n = 1'b1;
      src_req = 1'b0;
      repeat (3) tick();
      dst_ready = 1'b1;
      send_word(8'hC3);
      drain();
      chk_rx("mid", 8'hC3, 8'h00, 8'h00, 1);

      // 6: buffer full, pop and capture on the same edge
      rxq.delete();
      dst_ready = 1'b0;
      send_word(8'h40);
`ifdef CDC_DATA_RX_SKID_EN
      send_word(8'h41);
`endif
      src_data = 8'h42;
      src_req  = 1'b1;
      tick(); tick();
      chk("pc_pre_ack", {31'd0, src_ack}, 32'd0);
      dst_ready = 1'b1;
      tick();
      dst_ready = 1'b0;
      chk("pc_ack", {31'd0, src_ack}, 32'd1);
      chk("pc_valid", {31'd0, dst_valid}, 32'd1);
`ifdef CDC_DATA_RX_SKID_EN
      chk("pc_head", {24'd0, dst_data}, 32'h41);
`else
      chk("pc_head", {24'd0, dst_data}, 32'h42);
`endif
      src_req = 1'b0;
      n = 0;
      while (src_ack && n < 20) begin tick(); n++; end
      drain();
`ifdef CDC_DATA_RX_SKID_EN
      chk_rx("pc", 8'h40, 8'h41, 8'h42, 3);
`else
      chk_rx("pc", 8'h40, 8'h42, 8'h00, 2);
`endif

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
